// File: rtl/btb_pkg.sv
// Shared geometry, counter encodings and entry layout for the bimodal BTB.
// PC-to-index/tag helpers keep the address slicing in one place.
package btb_pkg;
   localparam int BTB_PC_WIDTH    = 32;
   localparam int BTB_INDEX_WIDTH = 6;
   localparam int BTB_TAG_WIDTH   = BTB_PC_WIDTH - BTB_INDEX_WIDTH - 2;

   localparam logic [1:0] CTR_SNT = 2'b00;
   localparam logic [1:0] CTR_WNT = 2'b01;
   localparam logic [1:0] CTR_WT  = 2'b10;
   localparam logic [1:0] CTR_ST  = 2'b11;

   localparam logic [1:0] CTR_RESET = CTR_WNT;
   localparam logic [1:0] CTR_ALLOC = CTR_WT;

   typedef struct packed {
      logic                     valid;
      logic [BTB_TAG_WIDTH-1:0] tag;
      logic [BTB_PC_WIDTH-1:0]  target;
      logic [1:0]               ctr;
   } btb_entry_t;

   // The low two bits are byte offsets within a word and never take part.
   function automatic logic [BTB_INDEX_WIDTH-1:0] idx_of(input logic [BTB_PC_WIDTH-1:0] pc);
      return pc[BTB_INDEX_WIDTH+1:2];
   endfunction

   function automatic logic [BTB_TAG_WIDTH-1:0] tag_of(input logic [BTB_PC_WIDTH-1:0] pc);
      return pc[BTB_PC_WIDTH-1:BTB_INDEX_WIDTH+2];
   endfunction
endpackage

// File: rtl/equal_nbit.sv
// Generic N-bit equality comparator.
module equal_nbit #(
   parameter int DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] i_a,
   input  logic [DATA_WIDTH-1:0] i_b,
   output logic                  o_eq
);
   assign o_eq = (i_a == i_b);
endmodule

// File: rtl/sat_ctr_2bit.sv
// Next state of a 2-bit saturating direction counter; pins at SNT and ST.
module sat_ctr_2bit
   import btb_pkg::*;
(
   input  logic [1:0] ctr,
   input  logic       taken,
   output logic [1:0] ctr_next
);
   always_comb begin
      ctr_next = ctr;
      if (taken) begin
         if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
      end else begin
         if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
      end
   end
endmodule

// File: rtl/btb_bimodal_predictor.sv
// Direct-mapped BTB with per-entry 2-bit direction counters: combinational
// lookup for fetch, single-port synchronous training from execute.
module btb_bimodal_predictor
   import btb_pkg::*;
#(
   parameter int PC_WIDTH    = BTB_PC_WIDTH,
   parameter int INDEX_WIDTH = BTB_INDEX_WIDTH,
   parameter int TAG_WIDTH   = PC_WIDTH - INDEX_WIDTH - 2
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic [PC_WIDTH-1:0] i_pc,
   output logic                o_hit,
   output logic                o_pred_taken,
   output logic [PC_WIDTH-1:0] o_pred_pc,
   input  logic                i_upd_en,
   input  logic [PC_WIDTH-1:0] i_upd_pc,
   input  logic                i_upd_taken,
   input  logic [PC_WIDTH-1:0] i_upd_target
);
   localparam int NUM_ENTRIES = 1 << INDEX_WIDTH;

   logic [NUM_ENTRIES-1:0] valid_q;
   logic [1:0]             ctr_q    [NUM_ENTRIES];
   logic [TAG_WIDTH-1:0]   tag_q    [NUM_ENTRIES];
   logic [PC_WIDTH-1:0]    target_q [NUM_ENTRIES];

   logic [INDEX_WIDTH-1:0] rd_idx, upd_idx;
   logic [TAG_WIDTH-1:0]   rd_tag, upd_tag;
   btb_entry_t             rd_entry;
   logic                   rd_tag_eq, upd_tag_eq, upd_hit;
   logic [1:0]             upd_ctr, upd_ctr_next;

   always_comb begin
      rd_idx   = idx_of(i_pc);
      rd_tag   = tag_of(i_pc);
      upd_idx  = idx_of(i_upd_pc);
      upd_tag  = tag_of(i_upd_pc);
      rd_entry = '{valid:  valid_q[rd_idx],
                   tag:    tag_q[rd_idx],
                   target: target_q[rd_idx],
                   ctr:    ctr_q[rd_idx]};
      upd_ctr  = ctr_q[upd_idx];
   end

   equal_nbit #(.DATA_WIDTH(TAG_WIDTH)) u_rd_cmp (
      .i_a  (rd_entry.tag),
      .i_b  (rd_tag),
      .o_eq (rd_tag_eq)
   );

   equal_nbit #(.DATA_WIDTH(TAG_WIDTH)) u_upd_cmp (
      .i_a  (tag_q[upd_idx]),
      .i_b  (upd_tag),
      .o_eq (upd_tag_eq)
   );

   sat_ctr_2bit u_ctr (
      .ctr      (upd_ctr),
      .taken    (i_upd_taken),
      .ctr_next (upd_ctr_next)
   );

   // Lookup reads the registered arrays only, so a same-cycle update is not
   // visible until the following cycle.
   always_comb begin
      o_hit        = rd_entry.valid & rd_tag_eq;
      o_pred_taken = o_hit & rd_entry.ctr[1];
      o_pred_pc    = o_pred_taken ? rd_entry.target : (i_pc + PC_WIDTH'(4));
      upd_hit      = valid_q[upd_idx] & upd_tag_eq;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         valid_q <= '0;
         for (int i = 0; i < NUM_ENTRIES; i++) ctr_q[i] <= CTR_RESET;
      end else if (i_upd_en) begin
         if (upd_hit) begin
            ctr_q[upd_idx] <= upd_ctr_next;
         end else if (i_upd_taken) begin
            valid_q[upd_idx] <= 1'b1;
            ctr_q[upd_idx]   <= CTR_ALLOC;
         end
      end
   end

   // Any taken update writes tag+target: on a hit the tag is unchanged, on a
   // miss it is the allocation. Gated by reset so a coincident update is lost.
   always_ff @(posedge i_clk) begin
      if (i_rst_n && i_upd_en && i_upd_taken) begin
         tag_q[upd_idx]    <= upd_tag;
         target_q[upd_idx] <= i_upd_target;
      end
   end
endmodule

// File: tb/tb_btb_bimodal_predictor.sv
// Directed plus randomized check of btb_bimodal_predictor against a
// table-based reference model of the BTB rules.
module tb_btb_bimodal_predictor;
   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b1;
   logic [31:0] i_pc = '0;
   logic        o_hit, o_pred_taken;
   logic [31:0] o_pred_pc;
   logic        i_upd_en = 1'b0;
   logic [31:0] i_upd_pc = '0;
   logic        i_upd_taken = 1'b0;
   logic [31:0] i_upd_target = '0;

   int checks = 0;
   int errors = 0;

   btb_bimodal_predictor dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_pc         (i_pc),
      .o_hit        (o_hit),
      .o_pred_taken (o_pred_taken),
      .o_pred_pc    (o_pred_pc),
      .i_upd_en     (i_upd_en),
      .i_upd_pc     (i_upd_pc),
      .i_upd_taken  (i_upd_taken),
      .i_upd_target (i_upd_target)
   );

   always #5 i_clk = ~i_clk;

   // Reference model: 64 entries, counter as an integer 0..3.
   bit          m_valid [64];
   int unsigned m_tag   [64];
   logic [31:0] m_tgt   [64];
   int          m_ctr   [64];

   function automatic int unsigned m_idx(input logic [31:0] pc);
      return (pc / 4) % 64;
   endfunction

   function automatic int unsigned m_tagv(input logic [31:0] pc);
      return pc / 256;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 64; i++) begin
         m_valid[i] = 0;
         m_ctr[i]   = 1;
      end
   endtask

   task automatic model_update(input logic [31:0] pc, input bit tk, input logic [31:0] tgt);
      int unsigned ix = m_idx(pc);
      bit hit = m_valid[ix] && (m_tag[ix] == m_tagv(pc));
      if (hit) begin
         if (tk) begin
            m_ctr[ix] = (m_ctr[ix] < 3) ? m_ctr[ix] + 1 : 3;
            m_tgt[ix] = tgt;
         end else begin
            m_ctr[ix] = (m_ctr[ix] > 0) ? m_ctr[ix] - 1 : 0;
         end
      end else if (tk) begin
         m_valid[ix] = 1;
         m_tag[ix]   = m_tagv(pc);
         m_tgt[ix]   = tgt;
         m_ctr[ix]   = 2;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      int unsigned ix = m_idx(i_pc);
      bit hit = m_valid[ix] && (m_tag[ix] == m_tagv(i_pc));
      bit tk  = hit && (m_ctr[ix] >= 2);
      logic [31:0] npc = tk ? m_tgt[ix] : i_pc + 32'd4;
      check({tag, ".hit"},   32'(o_hit),        32'(hit));
      check({tag, ".taken"}, 32'(o_pred_taken), 32'(tk));
      check({tag, ".pc"},    o_pred_pc,         npc);
   endtask

   task automatic check_out(input string tag, input bit hit, input bit tk, input logic [31:0] npc);
      check({tag, ".hit"},   32'(o_hit),        32'(hit));
      check({tag, ".taken"}, 32'(o_pred_taken), 32'(tk));
      check({tag, ".pc"},    o_pred_pc,         npc);
   endtask

   // Drive at negedge, let comb settle, compare with the model's view.
   task automatic set_in(input logic [31:0] pc, input bit en, input logic [31:0] upc,
                         input bit tk, input logic [31:0] tgt, input string tag);
      @(negedge i_clk);
      i_rst_n      = 1'b1;
      i_pc         = pc;
      i_upd_en     = en;
      i_upd_pc     = upc;
      i_upd_taken  = tk;
      i_upd_target = tgt;
      #2;
      check_model(tag);
   endtask

   task automatic tick();
      @(posedge i_clk);
      if (i_rst_n && i_upd_en) model_update(i_upd_pc, i_upd_taken, i_upd_target);
      #1;
   endtask

   initial begin
      // Mid-cycle reset with a coincident taken update that must be dropped.
      #2;
      i_rst_n      = 1'b0;
      i_pc         = 32'h100;
      i_upd_en     = 1'b1;
      i_upd_pc     = 32'h300;
      i_upd_taken  = 1'b1;
      i_upd_target = 32'h500;
      model_reset();
      #1;
      check_out("reset", 0, 0, 32'h104);
      tick();
      set_in(32'h300, 0, 0, 0, 0, "upd_in_reset");
      check_out("upd_in_reset_c", 0, 0, 32'h304);
      tick();

      // Allocate then predict.
      set_in(32'h100, 1, 32'h100, 1, 32'h40, "alloc");
      check_out("alloc_c", 0, 0, 32'h104);
      tick();
      set_in(32'h100, 0, 0, 0, 0, "alloc_pred");
      check_out("alloc_pred_c", 1, 1, 32'h40);
      tick();

      // Hysteresis: 10 -> 01 -> 00 -> 00, then 01 -> 10.
      for (int i = 0; i < 3; i++) begin
         set_in(32'h100, 1, 32'h100, 0, 0, "nt_train");
         tick();
      end
      set_in(32'h100, 0, 0, 0, 0, "sat_low");
      check_out("sat_low_c", 1, 0, 32'h104);
      tick();
      set_in(32'h100, 1, 32'h100, 1, 32'h40, "t_train1");
      tick();
      set_in(32'h100, 0, 0, 0, 0, "weak_nt");
      check_out("weak_nt_c", 1, 0, 32'h104);
      tick();
      set_in(32'h100, 1, 32'h100, 1, 32'h40, "t_train2");
      tick();
      set_in(32'h100, 0, 0, 0, 0, "weak_t");
      check_out("weak_t_c", 1, 1, 32'h40);
      tick();

      // Alias: not-taken miss leaves the entry, taken miss evicts it.
      set_in(32'h100, 1, 32'h1100, 0, 32'h2000, "alias_nt");
      tick();
      set_in(32'h100, 0, 0, 0, 0, "alias_keep");
      check_out("alias_keep_c", 1, 1, 32'h40);
      tick();
      set_in(32'h1100, 1, 32'h1100, 1, 32'h2000, "alias_t");
      check_out("alias_t_c", 0, 0, 32'h1104);
      tick();
      set_in(32'h100, 0, 0, 0, 0, "evicted");
      check_out("evicted_c", 0, 0, 32'h104);
      tick();
      set_in(32'h1100, 0, 0, 0, 0, "new_owner");
      check_out("new_owner_c", 1, 1, 32'h2000);
      tick();

      // Same-cycle read/write at the same index: no bypass.
      set_in(32'h200, 1, 32'h200, 1, 32'h80, "rw_same");
      check_out("rw_same_c", 0, 0, 32'h204);
      tick();
      set_in(32'h200, 0, 0, 0, 0, "rw_next");
      check_out("rw_next_c", 1, 1, 32'h80);
      tick();

      // PC+4 wrap at the top of the address space.
      set_in(32'hFFFF_FFFC, 0, 0, 0, 0, "wrap");
      check_out("wrap_c", 0, 0, 32'h0);
      tick();

      // Random traffic over a small PC pool to force aliasing and saturation;
      // update inputs are randomised even when disabled.
      for (int n = 0; n < 3000; n++) begin
         logic [31:0] pc, upc, tgt;
         bit en;
         pc  = {22'($urandom_range(0, 3)), 2'b00, 3'($urandom_range(0, 7)), 3'b000, 2'($urandom)};
         upc = {22'($urandom_range(0, 3)), 2'b00, 3'($urandom_range(0, 7)), 3'b000, 2'($urandom)};
         if ($urandom_range(0, 15) == 0) pc = $urandom;
         tgt = $urandom;
         en  = ($urandom_range(0, 3) != 0);
         set_in(pc, en, upc, 1'($urandom), tgt, "rand");
         if ($urandom_range(0, 99) == 0) begin
            #1;
            i_rst_n = 1'b0;
            model_reset();
            #1;
            check_model("rand_reset");
         end
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
